// File: rtl/serial_tx_16bits.sv
// serial_tx_16bits: 16-bit parallel-in, serial-out transmitter with valid/ready accept.
// Optional even-parity bit after the data word when SERIAL_TX_PARITY_EN is defined.
module serial_tx_16bits #(
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        sdo,
  output logic        frame,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_shift;
  logic [7:0]  r_div;
  logic [3:0]  r_bit;
  logic        w_accept;
  logic        w_bit_end;
  logic        w_cur;
  logic [15:0] w_shifted;
`ifdef SERIAL_TX_PARITY_EN
  logic        r_par;
`endif

  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_bit_end = (r_div == DIV_LAST);
  assign w_cur     = MSB_FIRST ? r_shift[15] : r_shift[0];
  assign w_shifted = MSB_FIRST ? {r_shift[14:0], 1'b0}
                               : {1'b0, r_shift[15:1]};

  // State register; reset aborts any word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: one bit slot lasts CLK_DIV cycles, DONE lasts one cycle
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_bit_end && (r_bit == 4'd15)) begin
`ifdef SERIAL_TX_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) w_next = S_DONE;
      end
`endif
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Shift register and bit/divider counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_div   <= '0;
      r_bit   <= '0;
    end else if (w_accept) begin
      r_shift <= in_data;
      r_div   <= '0;
      r_bit   <= '0;
    end else if (r_state == S_SHIFT) begin
      if (w_bit_end) begin
        r_div   <= '0;
        r_bit   <= r_bit + 4'd1;
        r_shift <= w_shifted;
      end else begin
        r_div <= r_div + 8'd1;
      end
`ifdef SERIAL_TX_PARITY_EN
    end else if (r_state == S_PARITY) begin
      if (w_bit_end) r_div <= '0;
      else           r_div <= r_div + 8'd1;
`endif
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Even parity of the word, latched with it so later in_data can't disturb it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ^in_data;
    end
  end
`endif

  // Outputs decode straight from state so reset takes effect without a clock
  always_comb begin
    in_ready = 1'b0;
    frame    = 1'b0;
    sdo      = 1'b1;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_SHIFT: begin
        frame = 1'b1;
        sdo   = w_cur;
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        frame = 1'b1;
        sdo   = r_par;
      end
`endif
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx_16bits.sv
// tb_serial_tx_16bits: directed bench for serial_tx_16bits.
// Unit A: MSB first, CLK_DIV=4.  Unit B: LSB first, CLK_DIV=1.
module tb_serial_tx_16bits;

`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] a_data, b_data;
  logic        a_valid, b_valid;
  logic        a_ready, a_sdo, a_frame, a_busy, a_done;
  logic        b_ready, b_sdo, b_frame, b_busy, b_done;

  int n_cmp = 0;
  int n_bad = 0;

  serial_tx_16bits #(.CLK_DIV(4), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .sdo(a_sdo), .frame(a_frame), .busy(a_busy), .done(a_done)
  );

  serial_tx_16bits #(.CLK_DIV(1), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .sdo(b_sdo), .frame(b_frame), .busy(b_busy), .done(b_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Offer one word to unit sel (0=A, 1=B) once it is idle; returns after accept edge
  task automatic send(input bit sel, input logic [15:0] data);
    int t = 0;
    @(negedge clk);
    while (!(sel ? b_ready : a_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout unit=%0d ready never rose", sel);
    end
    if (sel) begin b_valid = 1'b1; b_data = data; end
    else     begin a_valid = 1'b1; a_data = data; end
    @(posedge clk);
    #1;
    if (sel) begin b_valid = 1'b0; b_data = ~data; end
    else     begin a_valid = 1'b0; a_data = ~data; end
  endtask

  // Record what a unit puts out after an accept edge; k=1 is the first negedge after it
  task automatic capture(input bit sel, input int div,
                         output logic [15:0] w, output logic par,
                         output int fcnt, output int done_at, output int done_cnt,
                         output bit hold_err, output logic idle_after);
    int   total;
    int   slot;
    logic s, f, d, r, first_s;
    total = NB * div + 2;
    w = '0; par = 1'b0; fcnt = 0; done_at = -1; done_cnt = 0;
    hold_err = 1'b0; idle_after = 1'b0; first_s = 1'b0;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      s = sel ? b_sdo   : a_sdo;
      f = sel ? b_frame : a_frame;
      d = sel ? b_done  : a_done;
      r = sel ? b_ready : a_ready;
      if (f) fcnt++;
      if (d) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k <= NB * div) begin
        slot = (k - 1) / div;
        if (((k - 1) % div) == 0) begin
          first_s = s;
          if (slot < 16) begin
            if (sel) w[slot] = s;
            else     w[15 - slot] = s;
          end else begin
            par = s;
          end
        end else if (s !== first_s) begin
          hold_err = 1'b1;
        end
      end
      if (k == total) idle_after = r;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_data = '0; b_data = '0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (a_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", a_ready); end
    n_cmp++;
    if (a_sdo !== 1'b1) begin n_bad++; $display("FAIL reset_sdo got=%b exp=1", a_sdo); end
    n_cmp++;
    if ({a_frame, a_busy, a_done} !== 3'b000) begin
      n_bad++; $display("FAIL reset_fbd got=%b exp=000", {a_frame, a_busy, a_done});
    end
    n_cmp++;
    if ({b_ready, b_sdo, b_frame, b_busy, b_done} !== 5'b11000) begin
      n_bad++; $display("FAIL reset_b got=%b exp=11000", {b_ready, b_sdo, b_frame, b_busy, b_done});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_msb_div4();
    logic [15:0] vec [2] = '{16'hA5C3, 16'h3C01};
    logic        vpar [2] = '{1'b0, 1'b1};
    logic [15:0] w;
    logic        par, idle;
    int          fc, da, dc;
    bit          he;
    for (int i = 0; i < 2; i++) begin
      send(1'b0, vec[i]);
      capture(1'b0, 4, w, par, fc, da, dc, he, idle);
      n_cmp++;
      if (w !== vec[i]) begin n_bad++; $display("FAIL msb_word got=%h exp=%h", w, vec[i]); end
      n_cmp++;
      if (he !== 1'b0) begin n_bad++; $display("FAIL msb_hold got=%b exp=0", he); end
      n_cmp++;
      if (fc != NB * 4) begin n_bad++; $display("FAIL msb_frame_len got=%0d exp=%0d", fc, NB * 4); end
      n_cmp++;
      if (da != NB * 4 + 1 || dc != 1) begin
        n_bad++; $display("FAIL msb_done got_at=%0d cnt=%0d exp_at=%0d cnt=1", da, dc, NB * 4 + 1);
      end
      n_cmp++;
      if (idle !== 1'b1) begin n_bad++; $display("FAIL msb_idle_after got=%b exp=1", idle); end
`ifdef SERIAL_TX_PARITY_EN
      n_cmp++;
      if (par !== vpar[i]) begin n_bad++; $display("FAIL msb_parity got=%b exp=%b", par, vpar[i]); end
`else
      if (vpar[i] === 1'bx) $display("unused parity %b", par);
`endif
    end
  endtask

  task automatic test_lsb_div1();
    logic [15:0] w;
    logic        par, idle;
    int          fc, da, dc;
    bit          he;
    send(1'b1, 16'h0001);
    capture(1'b1, 1, w, par, fc, da, dc, he, idle);
    n_cmp++;
    if (w !== 16'h0001) begin n_bad++; $display("FAIL lsb_word got=%h exp=0001", w); end
    n_cmp++;
    if (fc != NB) begin n_bad++; $display("FAIL lsb_frame_len got=%0d exp=%0d", fc, NB); end
    n_cmp++;
    if (da != NB + 1 || dc != 1) begin
      n_bad++; $display("FAIL lsb_done got_at=%0d cnt=%0d exp_at=%0d cnt=1", da, dc, NB + 1);
    end
    n_cmp++;
    if (idle !== 1'b1) begin n_bad++; $display("FAIL lsb_idle_after got=%b exp=1", idle); end
    send(1'b1, 16'h8000);
    capture(1'b1, 1, w, par, fc, da, dc, he, idle);
    n_cmp++;
    if (w !== 16'h8000) begin n_bad++; $display("FAIL lsb_word2 got=%h exp=8000", w); end
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity();
    logic [15:0] w;
    logic        par, idle;
    int          fc, da, dc;
    bit          he;
    send(1'b0, 16'h0007);
    capture(1'b0, 4, w, par, fc, da, dc, he, idle);
    n_cmp++;
    if (par !== 1'b1) begin n_bad++; $display("FAIL par_0007 got=%b exp=1", par); end
    n_cmp++;
    if (da != 69) begin n_bad++; $display("FAIL par_done got=%0d exp=69", da); end
    n_cmp++;
    if (he !== 1'b0) begin n_bad++; $display("FAIL par_hold got=%b exp=0", he); end
    send(1'b0, 16'h0003);
    capture(1'b0, 4, w, par, fc, da, dc, he, idle);
    n_cmp++;
    if (par !== 1'b0) begin n_bad++; $display("FAIL par_0003 got=%b exp=0", par); end
    n_cmp++;
    if (w !== 16'h0003) begin n_bad++; $display("FAIL par_word got=%h exp=0003", w); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [15:0] vec [3] = '{16'h1357, 16'hBEEF, 16'h0F0F};
    logic [15:0] w;
    bit          busy_bad;
    logic        dn;
    int          t = 0;
    @(negedge clk);
    while (!b_ready && t < 200) begin @(negedge clk); t++; end
    b_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (b_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_gap word=%0d got=%b exp=1", i, b_ready); end
      b_data = vec[i];
      @(posedge clk);
      w = '0; busy_bad = 1'b0; dn = 1'b0;
      for (int k = 1; k <= NB + 1; k++) begin
        @(negedge clk);
        if (b_ready !== 1'b0 || b_busy !== 1'b1) busy_bad = 1'b1;
        if (k <= 16) w[k - 1] = b_sdo;
        if (k == NB + 1) dn = b_done;
        b_data = 16'hFFFF ^ 16'(k * 16'h0101);
      end
      n_cmp++;
      if (w !== vec[i]) begin n_bad++; $display("FAIL b2b_word%0d got=%h exp=%h", i, w, vec[i]); end
      n_cmp++;
      if (busy_bad) begin n_bad++; $display("FAIL b2b_busy%0d got=accepting exp=blocked", i); end
      n_cmp++;
      if (dn !== 1'b1) begin n_bad++; $display("FAIL b2b_done%0d got=%b exp=1", i, dn); end
    end
    b_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    logic        par, idle;
    int          fc, da, dc;
    bit          he;
    bit          saw_done = 1'b0;
    send(1'b0, 16'h1234);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (a_done) saw_done = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_ready, a_sdo, a_frame, a_busy, a_done} !== 5'b11000) begin
      n_bad++; $display("FAIL midrst_outs got=%b exp=11000", {a_ready, a_sdo, a_frame, a_busy, a_done});
    end
    @(posedge clk);
    #1;
    if (a_done) saw_done = 1'b1;
    n_cmp++;
    if (saw_done) begin n_bad++; $display("FAIL midrst_no_done got=1 exp=0"); end
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1'b1;
    a_data = 16'hFFFF;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_data = 16'h0000;
    capture(1'b0, 4, w, par, fc, da, dc, he, idle);
    n_cmp++;
    if (w !== 16'hFFFF) begin n_bad++; $display("FAIL midrst_word got=%h exp=FFFF", w); end
    n_cmp++;
    if (da != NB * 4 + 1 || dc != 1) begin
      n_bad++; $display("FAIL midrst_done got_at=%0d cnt=%0d exp_at=%0d", da, dc, NB * 4 + 1);
    end
  endtask

  initial begin
    test_reset();
    test_msb_div4();
    test_lsb_div1();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
